hdmi_out_fifo_fill_ctrl: RTL and testbench
==========================================

HDMI_OUT_FIFO_FILL_CTRL -- requirements
Module: hdmi_out_fifo_fill_ctrl

Interface
REQ-001 Parameter DEPTH_WIDTH, default 10: FIFO write depth width; depth = 2^DEPTH_WIDTH.
REQ-002 Parameter DATA_WIDTH, default 32: beat width.
REQ-003 Parameter ADDR_WIDTH, default 28: DDR read address width.
REQ-004 Parameter BURST_LEN, default 64: maximum beats per DDR read request; range 1..2^(DEPTH_WIDTH-1).
REQ-005 Parameter FRAME_BEATS, default 1024: beats per video frame.
REQ-006 Parameter FRAME_BASE, default 0: byte address of the first frame beat.
REQ-007 Parameter FLUSH_CYCLES, default 4: FIFO reset pulse length in cycles.
REQ-008 wr_clk  in  1  sole clock; FIFO write-side clock; rising-edge.
REQ-009 wr_rst_n  in  1  asynchronous, active-low reset.
REQ-010 frame_start  in  1  single-cycle pulse; begins a new frame.
REQ-011 fifo_water_level  in  DEPTH_WIDTH+1  FIFO write water level.
REQ-012 fifo_full  in  1  FIFO full flag.
REQ-013 fifo_wr_en  out  1  FIFO write enable.
REQ-014 fifo_wr_data  out  DATA_WIDTH  FIFO write data.
REQ-015 fifo_rst  out  1  active-high FIFO reset, to both FIFO reset ports.
REQ-016 ddr_rd_req  out  1  read request; held until ddr_rd_ack.
REQ-017 ddr_rd_addr  out  ADDR_WIDTH  request byte address; stable while ddr_rd_req is high.
REQ-018 ddr_rd_len  out  DEPTH_WIDTH  request beat count; stable while ddr_rd_req is high.
REQ-019 ddr_rd_ack  in  1  request accepted in the cycle it is high together with ddr_rd_req.
REQ-020 ddr_rd_valid  in  1  return beat valid.
REQ-021 ddr_rd_data  in  DATA_WIDTH  return beat.
REQ-022 frame_done  out  1  one-cycle pulse after the last frame beat is written.
REQ-023 overflow_err  out  1  sticky; set when a beat is dropped because of fifo_full.

Function
REQ-024 The FSM SHALL use states IDLE, FLUSH, WAIT_SPACE, REQ, XFER, DRAIN and DONE.
REQ-025 IDLE: on frame_start, go to FLUSH; load remaining = FRAME_BEATS and addr = FRAME_BASE.
REQ-026 FLUSH: fifo_rst=1 for exactly FLUSH_CYCLES cycles, then go to WAIT_SPACE.
REQ-027 WAIT_SPACE: when 2^DEPTH_WIDTH - fifo_water_level >= len, go to REQ; len = min(BURST_LEN, remaining).
REQ-028 REQ: ddr_rd_req=1; on ddr_rd_ack, latch len as outstanding and go to XFER.
REQ-029 XFER: each ddr_rd_valid drives fifo_wr_en=1 and fifo_wr_data=ddr_rd_data in the same cycle (zero-latency pass-through) and decrements outstanding and remaining.
REQ-030 XFER end: when outstanding reaches 0, addr += len*(DATA_WIDTH/8). If remaining is 0, go to DONE; otherwise go to WAIT_SPACE.
REQ-031 DONE: pulse frame_done for one cycle, then go to IDLE.
REQ-032 ddr_rd_valid with fifo_full=1 SHALL NOT assert fifo_wr_en, SHALL still count the beat, and SHALL set overflow_err.
REQ-033 ddr_rd_valid outside XFER/DRAIN SHALL be ignored.
REQ-034 frame_start in FLUSH, WAIT_SPACE or DONE: restart at FLUSH with counters reloaded; the flush count restarts.
REQ-035 frame_start in REQ: complete the handshake; the acked burst SHALL NOT start. Go to FLUSH if no ack; on ack, go to DRAIN with outstanding = len.
REQ-036 frame_start in XFER: go to DRAIN.
REQ-037 DRAIN: discard beats (fifo_wr_en=0) until outstanding = 0, then go to FLUSH with counters reloaded.
REQ-038 frame_start in DRAIN: ignored.
REQ-039 frame_start coinciding with the final beat: DRAIN is skipped; go to FLUSH and suppress frame_done.
REQ-040 At most one DDR request SHALL be outstanding.
REQ-041 Address arithmetic wraps modulo 2^ADDR_WIDTH.

Reset
REQ-042 On wr_rst_n=0, asynchronously: state=IDLE; fifo_rst=1; ddr_rd_req=0; fifo_wr_en=0; fifo_wr_data=0; ddr_rd_addr=FRAME_BASE; ddr_rd_len=0; frame_done=0; overflow_err=0; all counters 0.
REQ-043 fifo_rst SHALL deassert on the first clock edge after wr_rst_n rises.
REQ-044 Reset asserted mid-burst SHALL abandon the burst; recovery relies on the system resetting the DDR port.

Structure
REQ-045 FSM state encoding and the ceil-log2 helper SHALL live in a shared package, hdmi_out_pkg.
REQ-046 One sub-module SHALL exist: hdmi_out_burst_cnt, the loadable down-counter used for both outstanding and remaining.
REQ-047 The block SHALL sit on the write side of the HDMI-out FIFO; the FIFO itself is external.

Verification (DEPTH_WIDTH=10, BURST_LEN=64, FRAME_BEATS=200, DATA_WIDTH=32)
REQ-048 Normal frame, level 0, ack after 2 cycles, valid every cycle -> 4 requests: len 64/64/64/8 at addr 0/256/512/768; 200 writes; one frame_done.
REQ-049 Backpressure: level held at 980 -> no ddr_rd_req; dropping level to 960 -> request issued the next cycle.
REQ-050 fifo_full=1 on beat 10 of burst 1 -> that beat not written, overflow_err=1 and sticky, remaining count unaffected.
REQ-051 frame_start at beat 30 of burst 2 -> 34 beats discarded, then fifo_rst high 4 cycles, next request at addr 0, len 64.
REQ-052 wr_rst_n low in XFER -> all outputs at reset values immediately; fifo_rst released on the first edge after release.
REQ-053 frame_start on the 200th beat -> no frame_done; FLUSH entered.

Source files
------------

// File: rtl/hdmi_out_pkg.sv
// Shared definitions for the HDMI-out FIFO fill path: FSM state encoding
// and a constant ceil-log2 helper used for counter sizing.
package hdmi_out_pkg;

  localparam int STATE_W = 3;

  localparam logic [STATE_W-1:0] ST_IDLE       = 3'd0;
  localparam logic [STATE_W-1:0] ST_FLUSH      = 3'd1;
  localparam logic [STATE_W-1:0] ST_WAIT_SPACE = 3'd2;
  localparam logic [STATE_W-1:0] ST_REQ        = 3'd3;
  localparam logic [STATE_W-1:0] ST_XFER       = 3'd4;
  localparam logic [STATE_W-1:0] ST_DRAIN      = 3'd5;
  localparam logic [STATE_W-1:0] ST_DONE       = 3'd6;

  // Bits needed to hold values 0..value-1; never less than 1.
  function automatic int clog2(input int value);
    int result;
    result = 1;
    for (int i = 1; i < 31; i++) begin
      if ((1 << i) < value) result = i + 1;
    end
    return result;
  endfunction

endpackage

// File: rtl/hdmi_out_burst_cnt.sv
// Loadable down-counter shared by the outstanding-beat and remaining-beat
// trackers. Load wins over decrement; decrement saturates at zero.
module hdmi_out_burst_cnt #(
  parameter int WIDTH = 10
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             dec,
  output logic [WIDTH-1:0] cnt,
  output logic             last
);

  // Count register: reload on request, otherwise step down once per beat.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (dec && (cnt != '0)) begin
      cnt <= cnt - 1'b1;
    end
  end

  // Flags the beat that will bring the count to zero.
  assign last = (cnt == WIDTH'(1));

endmodule

// File: rtl/hdmi_out_fifo_fill_ctrl.sv
// Write-side fill controller for the HDMI-out FIFO: issues DDR read bursts
// whenever the FIFO has room, streams returned beats straight into the FIFO,
// and restarts cleanly (drain, flush) when a new frame is requested mid-way.
module hdmi_out_fifo_fill_ctrl
  import hdmi_out_pkg::*;
#(
  parameter int          DEPTH_WIDTH  = 10,
  parameter int          DATA_WIDTH   = 32,
  parameter int          ADDR_WIDTH   = 28,
  parameter int          BURST_LEN    = 64,
  parameter int          FRAME_BEATS  = 1024,
  parameter int unsigned FRAME_BASE   = 0,
  parameter int          FLUSH_CYCLES = 4
) (
  input  logic                  wr_clk,
  input  logic                  wr_rst_n,
  input  logic                  frame_start,
  input  logic [DEPTH_WIDTH:0]  fifo_water_level,
  input  logic                  fifo_full,
  output logic                  fifo_wr_en,
  output logic [DATA_WIDTH-1:0] fifo_wr_data,
  output logic                  fifo_rst,
  output logic                  ddr_rd_req,
  output logic [ADDR_WIDTH-1:0] ddr_rd_addr,
  output logic [DEPTH_WIDTH-1:0] ddr_rd_len,
  input  logic                  ddr_rd_ack,
  input  logic                  ddr_rd_valid,
  input  logic [DATA_WIDTH-1:0] ddr_rd_data,
  output logic                  frame_done,
  output logic                  overflow_err
);

  localparam int REM_W      = clog2(FRAME_BEATS + 1);
  localparam int FLUSH_W    = clog2(FLUSH_CYCLES + 1);
  localparam int LEVEL_W    = DEPTH_WIDTH + 2;
  localparam int DEPTH      = 1 << DEPTH_WIDTH;
  localparam int BEAT_BYTES = DATA_WIDTH / 8;

  logic [STATE_W-1:0]     state;
  logic [STATE_W-1:0]     next_state;
  logic [FLUSH_W-1:0]     flush_cnt;
  logic [DEPTH_WIDTH-1:0] out_cnt;
  logic                   out_last;
  logic [REM_W-1:0]       rem_cnt;
  logic                   rem_last;
  logic [DEPTH_WIDTH-1:0] len_next;
  logic [LEVEL_W-1:0]     level_ext;
  logic [LEVEL_W-1:0]     free_space;
  logic                   space_ok;
  logic                   in_xfer;
  logic                   in_drain;
  logic                   in_req;
  logic                   beat;
  logic                   burst_end;
  logic                   flush_last;
  logic                   reload;
  logic                   flush_restart;
  logic [ADDR_WIDTH-1:0]  burst_bytes;

  assign in_xfer  = (state == ST_XFER);
  assign in_drain = (state == ST_DRAIN);
  assign in_req   = (state == ST_REQ);

  // A beat is only consumed while a burst is in flight; stray valids elsewhere are ignored.
  assign beat      = ddr_rd_valid && (in_xfer || in_drain) && (out_cnt != '0);
  assign burst_end = beat && out_last;

  // Beats pass straight through to the FIFO; a full FIFO drops the beat but it still counts.
  assign fifo_wr_en   = beat && in_xfer && !fifo_full;
  assign fifo_wr_data = in_xfer ? ddr_rd_data : '0;

  // Next burst length is the smaller of the burst cap and what the frame still needs.
  always_comb begin
    len_next = DEPTH_WIDTH'(BURST_LEN);
    if (32'(rem_cnt) < 32'(BURST_LEN)) len_next = DEPTH_WIDTH'(rem_cnt);
  end

  assign level_ext  = LEVEL_W'(fifo_water_level);
  assign free_space = LEVEL_W'(DEPTH) - level_ext;
  assign space_ok   = (level_ext <= LEVEL_W'(DEPTH)) && (free_space >= LEVEL_W'(len_next));
  assign flush_last = (flush_cnt == FLUSH_W'(FLUSH_CYCLES - 1));

  // Frame sequencing and the various restart paths.
  always_comb begin
    next_state = state;
    case (state)
      ST_IDLE: begin
        if (frame_start) next_state = ST_FLUSH;
      end
      ST_FLUSH: begin
        if (frame_start)     next_state = ST_FLUSH;
        else if (flush_last) next_state = ST_WAIT_SPACE;
      end
      ST_WAIT_SPACE: begin
        if (frame_start)   next_state = ST_FLUSH;
        else if (space_ok) next_state = ST_REQ;
      end
      ST_REQ: begin
        // An acked request must still be drained even if the frame restarts.
        if (ddr_rd_ack)       next_state = frame_start ? ST_DRAIN : ST_XFER;
        else if (frame_start) next_state = ST_FLUSH;
      end
      ST_XFER: begin
        // A restart landing on the final beat needs no drain and gets no frame_done.
        if (burst_end) begin
          if (frame_start)   next_state = ST_FLUSH;
          else if (rem_last) next_state = ST_DONE;
          else               next_state = ST_WAIT_SPACE;
        end else if (frame_start) begin
          next_state = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        if (burst_end) next_state = ST_FLUSH;
      end
      ST_DONE: begin
        next_state = frame_start ? ST_FLUSH : ST_IDLE;
      end
      default: next_state = ST_IDLE;
    endcase
  end

  // Every entry into FLUSH (including a restart while flushing) reloads the frame counters.
  assign reload        = (next_state == ST_FLUSH);
  assign flush_restart = reload && ((state != ST_FLUSH) || frame_start);
  assign burst_bytes   = ADDR_WIDTH'(ddr_rd_len) * ADDR_WIDTH'(BEAT_BYTES);

  // State, registered handshake outputs, flush timer and read address.
  always_ff @(posedge wr_clk or negedge wr_rst_n) begin
    if (!wr_rst_n) begin
      state        <= ST_IDLE;
      fifo_rst     <= 1'b1;
      ddr_rd_req   <= 1'b0;
      ddr_rd_addr  <= ADDR_WIDTH'(FRAME_BASE);
      ddr_rd_len   <= '0;
      frame_done   <= 1'b0;
      overflow_err <= 1'b0;
      flush_cnt    <= '0;
    end else begin
      state      <= next_state;
      fifo_rst   <= (next_state == ST_FLUSH);
      ddr_rd_req <= (next_state == ST_REQ);
      frame_done <= (next_state == ST_DONE);
      if (beat && in_xfer && fifo_full) overflow_err <= 1'b1;
      if (flush_restart)          flush_cnt <= '0;
      else if (state == ST_FLUSH) flush_cnt <= flush_cnt + 1'b1;
      if (reload)                      ddr_rd_addr <= ADDR_WIDTH'(FRAME_BASE);
      else if (burst_end && in_xfer)   ddr_rd_addr <= ddr_rd_addr + burst_bytes;
      if ((state == ST_WAIT_SPACE) && (next_state == ST_REQ)) ddr_rd_len <= len_next;
    end
  end

  // Beats still owed by the DDR port for the accepted request.
  hdmi_out_burst_cnt #(
    .WIDTH (DEPTH_WIDTH)
  ) u_outstanding (
    .clk      (wr_clk),
    .rst_n    (wr_rst_n),
    .load     (in_req && ddr_rd_ack),
    .load_val (ddr_rd_len),
    .dec      (beat),
    .cnt      (out_cnt),
    .last     (out_last)
  );

  // Beats still needed to complete the frame.
  hdmi_out_burst_cnt #(
    .WIDTH (REM_W)
  ) u_remaining (
    .clk      (wr_clk),
    .rst_n    (wr_rst_n),
    .load     (reload),
    .load_val (REM_W'(FRAME_BEATS)),
    .dec      (beat && in_xfer),
    .cnt      (rem_cnt),
    .last     (rem_last)
  );

endmodule

// File: tb/tb_hdmi_out_fifo_fill_ctrl.sv
// Directed bench for hdmi_out_fifo_fill_ctrl with a 200-beat frame,
// 64-beat bursts and a 1024-entry FIFO.
module tb_hdmi_out_fifo_fill_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        frame_start = 1'b0;
  logic [10:0] level = '0;
  logic        fifo_full = 1'b0;
  logic        fifo_wr_en;
  logic [31:0] fifo_wr_data;
  logic        fifo_rst;
  logic        ddr_rd_req;
  logic [27:0] ddr_rd_addr;
  logic [9:0]  ddr_rd_len;
  logic        ddr_rd_ack = 1'b0;
  logic        ddr_rd_valid = 1'b0;
  logic [31:0] ddr_rd_data = '0;
  logic        frame_done;
  logic        overflow_err;

  int n_cmp = 0;
  int n_err = 0;
  int wr_count = 0;
  int done_count = 0;
  int ack_count = 0;

  hdmi_out_fifo_fill_ctrl #(
    .DEPTH_WIDTH  (10),
    .DATA_WIDTH   (32),
    .ADDR_WIDTH   (28),
    .BURST_LEN    (64),
    .FRAME_BEATS  (200),
    .FRAME_BASE   (0),
    .FLUSH_CYCLES (4)
  ) dut (
    .wr_clk           (clk),
    .wr_rst_n         (rst_n),
    .frame_start      (frame_start),
    .fifo_water_level (level),
    .fifo_full        (fifo_full),
    .fifo_wr_en       (fifo_wr_en),
    .fifo_wr_data     (fifo_wr_data),
    .fifo_rst         (fifo_rst),
    .ddr_rd_req       (ddr_rd_req),
    .ddr_rd_addr      (ddr_rd_addr),
    .ddr_rd_len       (ddr_rd_len),
    .ddr_rd_ack       (ddr_rd_ack),
    .ddr_rd_valid     (ddr_rd_valid),
    .ddr_rd_data      (ddr_rd_data),
    .frame_done       (frame_done),
    .overflow_err     (overflow_err)
  );

  always #5 clk = ~clk;

  // Event counters sampled on the active edge (pre-update values).
  always @(posedge clk) begin
    if (fifo_wr_en) wr_count++;
    if (frame_done) done_count++;
    if (ddr_rd_req && ddr_rd_ack) ack_count++;
  end

  initial begin
    #1000000;
    $display("FAIL global_timeout: observed hang expected finish");
    $fatal(1, "timeout");
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic start_frame();
    frame_start = 1'b1;
    step();
    frame_start = 1'b0;
  endtask

  // Counts consecutive cycles with fifo_rst high starting at the current sample.
  task automatic check_flush(input string tag);
    int n;
    n = 0;
    while (fifo_rst === 1'b1 && n < 20) begin
      n++;
      step();
    end
    check(tag, 64'(n), 64'd4);
  endtask

  task automatic wait_req(input string tag);
    int n;
    n = 0;
    while (ddr_rd_req !== 1'b1 && n < 200) begin
      step();
      n++;
    end
    check(tag, 64'(ddr_rd_req), 64'd1);
  endtask

  // Waits for a request, checks it, acks it two cycles later.
  task automatic do_ack(input string tag, input logic [27:0] exp_addr, input int exp_len);
    wait_req({tag, "_req"});
    check({tag, "_addr"}, 64'(ddr_rd_addr), 64'(exp_addr));
    check({tag, "_len"}, 64'(ddr_rd_len), 64'(exp_len));
    step();
    step();
    check({tag, "_req_held"}, 64'(ddr_rd_req), 64'd1);
    ddr_rd_ack = 1'b1;
    step();
    ddr_rd_ack = 1'b0;
    check({tag, "_req_drop"}, 64'(ddr_rd_req), 64'd0);
  endtask

  // Serves one burst with a beat every cycle; optional full beat and restart beat.
  task automatic burst(input string tag, input logic [27:0] exp_addr, input int exp_len,
                       input int full_at, input int fs_at);
    int nb;
    do_ack(tag, exp_addr, exp_len);
    nb = (fs_at != 0 && fs_at < exp_len) ? fs_at : exp_len;
    for (int b = 1; b <= nb; b++) begin
      ddr_rd_valid = 1'b1;
      ddr_rd_data  = $urandom;
      fifo_full    = (b == full_at);
      frame_start  = (b == fs_at);
      #1;
      if (b == 1) begin
        check({tag, "_pass_wr_en"}, 64'(fifo_wr_en), 64'd1);
        check({tag, "_pass_data"}, 64'(fifo_wr_data), 64'(ddr_rd_data));
      end
      if (b == full_at) check({tag, "_full_no_wr"}, 64'(fifo_wr_en), 64'd0);
      step();
      ddr_rd_valid = 1'b0;
      fifo_full    = 1'b0;
      frame_start  = 1'b0;
      if (b == full_at) check({tag, "_overflow_set"}, 64'(overflow_err), 64'd1);
    end
  endtask

  initial begin
    logic any_req;
    logic any_wr;
    logic any_rst;

    // ---- Reset values, asynchronous assertion ----
    #1 rst_n = 1'b0;
    ddr_rd_valid = 1'b1;
    ddr_rd_data  = 32'hDEADBEEF;
    #2;
    check("rst_fifo_rst", 64'(fifo_rst), 64'd1);
    check("rst_req", 64'(ddr_rd_req), 64'd0);
    check("rst_wr_en", 64'(fifo_wr_en), 64'd0);
    check("rst_wr_data", 64'(fifo_wr_data), 64'd0);
    check("rst_addr", 64'(ddr_rd_addr), 64'd0);
    check("rst_len", 64'(ddr_rd_len), 64'd0);
    check("rst_frame_done", 64'(frame_done), 64'd0);
    check("rst_overflow", 64'(overflow_err), 64'd0);
    ddr_rd_valid = 1'b0;
    ddr_rd_data  = '0;
    step();
    step();
    rst_n = 1'b1;
    #1;
    check("rst_release_fifo_rst_held", 64'(fifo_rst), 64'd1);
    step();
    check("rst_release_fifo_rst_low", 64'(fifo_rst), 64'd0);

    // ---- Normal frame: 64/64/64/8 at 0/256/512/768 ----
    wr_count = 0; done_count = 0; ack_count = 0;
    start_frame();
    check_flush("n_flush_len");
    burst("n_b1", 28'd0, 64, 0, 0);
    burst("n_b2", 28'd256, 64, 0, 0);
    burst("n_b3", 28'd512, 64, 0, 0);
    burst("n_b4", 28'd768, 8, 0, 0);
    check("n_frame_done_hi", 64'(frame_done), 64'd1);
    step();
    check("n_frame_done_lo", 64'(frame_done), 64'd0);
    check("n_writes", 64'(wr_count), 64'd200);
    check("n_done_count", 64'(done_count), 64'd1);
    check("n_ack_count", 64'(ack_count), 64'd4);
    check("n_no_overflow", 64'(overflow_err), 64'd0);

    // ---- Backpressure, then full FIFO on beat 10 of burst 1 ----
    wr_count = 0; done_count = 0;
    level = 11'd980;
    start_frame();
    check_flush("bp_flush_len");
    any_req = 1'b0;
    for (int i = 0; i < 20; i++) begin
      step();
      any_req = any_req | ddr_rd_req;
    end
    check("bp_no_req_980", 64'(any_req), 64'd0);
    level = 11'd960;
    step();
    check("bp_req_next_cycle_960", 64'(ddr_rd_req), 64'd1);
    level = 11'd0;
    burst("of_b1", 28'd0, 64, 10, 0);
    burst("of_b2", 28'd256, 64, 0, 0);
    burst("of_b3", 28'd512, 64, 0, 0);
    burst("of_b4", 28'd768, 8, 0, 0);
    step();
    check("of_sticky", 64'(overflow_err), 64'd1);
    check("of_writes", 64'(wr_count), 64'd199);
    check("of_done_count", 64'(done_count), 64'd1);

    // ---- Restart at beat 30 of burst 2: 34 beats drained ----
    wr_count = 0;
    start_frame();
    check_flush("rs_flush_len1");
    burst("rs_b1", 28'd0, 64, 0, 0);
    burst("rs_b2", 28'd256, 64, 0, 30);
    check("rs_no_flush_in_drain", 64'(fifo_rst), 64'd0);
    any_wr = 1'b0;
    any_rst = 1'b0;
    for (int i = 1; i <= 34; i++) begin
      ddr_rd_valid = 1'b1;
      ddr_rd_data  = $urandom;
      #1;
      any_wr = any_wr | fifo_wr_en;
      step();
      ddr_rd_valid = 1'b0;
      if (i < 34) any_rst = any_rst | fifo_rst;
    end
    check("rs_drain_no_writes", 64'(any_wr), 64'd0);
    check("rs_drain_no_early_flush", 64'(any_rst), 64'd0);
    check("rs_writes", 64'(wr_count), 64'd94);
    check_flush("rs_flush_len2");
    do_ack("rs_next", 28'd0, 64);

    // ---- Reset asserted mid-burst ----
    for (int i = 0; i < 5; i++) begin
      ddr_rd_valid = 1'b1;
      ddr_rd_data  = $urandom;
      step();
    end
    ddr_rd_data = 32'hA5A5A5A5;
    rst_n = 1'b0;
    #1;
    check("mr_fifo_rst", 64'(fifo_rst), 64'd1);
    check("mr_req", 64'(ddr_rd_req), 64'd0);
    check("mr_wr_en", 64'(fifo_wr_en), 64'd0);
    check("mr_wr_data", 64'(fifo_wr_data), 64'd0);
    check("mr_addr", 64'(ddr_rd_addr), 64'd0);
    check("mr_len", 64'(ddr_rd_len), 64'd0);
    check("mr_overflow_cleared", 64'(overflow_err), 64'd0);
    ddr_rd_valid = 1'b0;
    step();
    step();
    rst_n = 1'b1;
    #1;
    check("mr_release_fifo_rst_held", 64'(fifo_rst), 64'd1);
    step();
    check("mr_release_fifo_rst_low", 64'(fifo_rst), 64'd0);

    // ---- Restart on the 200th beat: no frame_done ----
    wr_count = 0; done_count = 0;
    start_frame();
    check_flush("lb_flush_len1");
    burst("lb_b1", 28'd0, 64, 0, 0);
    burst("lb_b2", 28'd256, 64, 0, 0);
    burst("lb_b3", 28'd512, 64, 0, 0);
    burst("lb_b4", 28'd768, 8, 0, 8);
    check("lb_no_frame_done", 64'(frame_done), 64'd0);
    check("lb_flush_entered", 64'(fifo_rst), 64'd1);
    check_flush("lb_flush_len2");
    check("lb_done_count", 64'(done_count), 64'd0);
    check("lb_writes", 64'(wr_count), 64'd200);
    wait_req("lb_next_req");
    check("lb_next_addr", 64'(ddr_rd_addr), 64'd0);
    check("lb_next_len", 64'(ddr_rd_len), 64'd64);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
